// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush controller for an N-stage in-order pipeline (stage 0 youngest).
//   The stall path is combinational. A flush whose source stage is frozen by an
//   older stall is held pending and issued in the first unblocked cycle. The
//   block also counts request-stall cycles and raises a sticky deadlock flag.
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   rdy_in        global ready; 0 freezes the whole pipe
//   stall_req_i   per-stage stall request (level)
//   flush_req_i   per-stage flush request (pulse, bit 0 ignored)
//   cnt_clr_i     synchronous clear of stall_cnt_o
//   stall_o       per-stage register hold
//   bubble_o      per-stage NOP insert
//   flush_o       per-stage invalidate
//   stall_cnt_o   saturating request-stall cycle count
//   timeout_o     sticky stall-deadlock flag
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_in,
    input  logic [NUM_STAGES-1:0] stall_req_i,
    input  logic [NUM_STAGES-1:0] flush_req_i,
    input  logic                  cnt_clr_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] bubble_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic                  timeout_o
);

    localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [IW-1:0]         pend_q, pend_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WW-1:0]         wd_q, wd_d;
    logic                  to_q, to_d;

    logic                  any_stall;
    logic [IW-1:0]         k, jn, j;
    logic                  issue;
    logic [NUM_STAGES-1:0] stall_path, bubble_path, flush_mask;

    always_comb begin
        any_stall = |stall_req_i;
        k  = '0;
        jn = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (stall_req_i[i]) k = IW'(i);
        end
        for (int unsigned i = 1; i < NUM_STAGES; i++) begin
            if (flush_req_i[i]) jn = IW'(i);
        end
        // Oldest requester wins; pending register doubles as the "none" (0) source.
        j = (jn > pend_q) ? jn : pend_q;
        issue = rdy_in && (j != '0) && (!any_stall || (j > k));

        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            stall_path[i]  = any_stall && (i <= 32'(k));
            bubble_path[i] = any_stall && (i == 32'(k) + 32'd1);
            flush_mask[i]  = issue && (i < 32'(j));
        end

        stall_o     = '0;
        bubble_o    = '0;
        flush_o     = '0;
        stall_cnt_o = '0;
        timeout_o   = 1'b0;
        if (!rst) begin
            stall_cnt_o = cnt_q;
            timeout_o   = to_q;
            if (!rdy_in) begin
                stall_o = '1;
            end else begin
                stall_o  = stall_path & ~flush_mask;
                bubble_o = bubble_path & ~flush_mask;
                flush_o  = flush_mask;
            end
        end

        // While frozen, j already folds in pend_q, so pending holds or is upgraded.
        pend_d = issue ? '0 : j;

        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (rdy_in && any_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        wd_d = wd_q;
        to_d = to_q;
        if (rdy_in) begin
            if (!any_stall) begin
                wd_d = '0;
            end else if (!to_q) begin
                wd_d = wd_q + 1'b1;
                if (wd_q == WW'(TIMEOUT - 1)) to_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
            wd_q   <= '0;
            to_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            wd_q   <= wd_d;
            to_q   <= to_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver computes expected outputs from
// a behavioural model and queues them; a monitor pops and compares each cycle.
module tb_pipe_hazard_ctrl;

    localparam int N  = 5;
    localparam int CW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy_in = 1'b1;
    logic [N-1:0]  stall_req_i = '0;
    logic [N-1:0]  flush_req_i = '0;
    logic          cnt_clr_i = 1'b0;
    logic [N-1:0]  stall_o, bubble_o, flush_o;
    logic [CW-1:0] stall_cnt_o;
    logic          timeout_o;

    pipe_hazard_ctrl #(.NUM_STAGES(N), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .stall_req_i(stall_req_i), .flush_req_i(flush_req_i), .cnt_clr_i(cnt_clr_i),
        .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
        .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st, bu, fl, cnt, to;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   issued = 0;
    int   popped = 0;

    // model state
    int m_pend = 0, m_cnt = 0, m_wd = 0, m_to = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit rdy, input int st, input int fl, input bit clr);
        exp_t e;
        int k, jn, j, mask;
        bit issue;
        @(posedge clk);
        #1;
        rst = r; rdy_in = rdy; stall_req_i = N'(st); flush_req_i = N'(fl); cnt_clr_i = clr;

        k = -1;
        for (int i = 0; i < N; i++) if (st[i]) k = i;
        jn = 0;
        for (int i = 1; i < N; i++) if (fl[i]) jn = i;
        j = (jn > m_pend) ? jn : m_pend;
        issue = rdy && (j >= 1) && (j > k);

        e = '{st: 0, bu: 0, fl: 0, cnt: 0, to: 0};
        if (!r) begin
            e.cnt = m_cnt;
            e.to  = m_to;
            if (!rdy) begin
                e.st = (1 << N) - 1;
            end else begin
                e.st = (k >= 0) ? ((1 << (k + 1)) - 1) : 0;
                e.bu = (k >= 0 && k < N - 1) ? (1 << (k + 1)) : 0;
                if (issue) begin
                    mask = (1 << j) - 1;
                    e.fl = mask;
                    e.st = e.st & ~mask;
                    e.bu = e.bu & ~mask;
                end
            end
        end
        q.push_back(e);
        issued++;

        if (r) begin
            m_pend = 0; m_cnt = 0; m_wd = 0; m_to = 0;
        end else begin
            m_pend = issue ? 0 : j;
            if (clr) m_cnt = 0;
            else if (rdy && k >= 0 && m_cnt < (1 << CW) - 1) m_cnt++;
            if (rdy) begin
                if (k < 0) m_wd = 0;
                else if (m_to == 0) begin
                    m_wd++;
                    if (m_wd == TO) m_to = 1;
                end
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                popped++;
                chk("stall_o",  int'(stall_o),     e.st);
                chk("bubble_o", int'(bubble_o),    e.bu);
                chk("flush_o",  int'(flush_o),     e.fl);
                chk("stall_cnt",int'(stall_cnt_o), e.cnt);
                chk("timeout",  int'(timeout_o),   e.to);
            end
        end
    end

    initial begin : driver
        int st;
        int fl;
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        // stall at stage 2
        repeat (3) cyc(0, 1, 5'b00100, 0, 0);
        cyc(0, 1, 0, 0, 0);
        // plain flush
        cyc(0, 1, 0, 5'b00100, 0);
        cyc(0, 1, 0, 0, 0);
        // flush blocked by older stall
        cyc(0, 1, 5'b01000, 5'b00100, 0);
        repeat (3) cyc(0, 1, 5'b01000, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0);
        // pending upgraded by older request, younger dropped
        cyc(0, 1, 5'b01000, 5'b00010, 0);
        cyc(0, 1, 5'b01000, 5'b01000, 0);
        cyc(0, 1, 5'b01000, 5'b00010, 0);
        repeat (2) cyc(0, 1, 0, 0, 0);
        // global freeze, with a flush latched while frozen
        repeat (2) cyc(0, 0, 5'b00010, 0, 0);
        cyc(0, 0, 5'b00010, 5'b10000, 0);
        repeat (2) cyc(0, 1, 0, 0, 0);
        // deadlock timeout, saturation, clear, reset
        repeat (10) cyc(0, 1, 5'b10000, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        repeat (8) cyc(0, 1, 5'b00001, 0, 0);
        cyc(0, 1, 5'b00001, 0, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 5'b00100, 5'b11110, 0);
        repeat (2) cyc(0, 1, 0, 0, 0);
        // random
        st = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: st = 0;
                    1, 2: st = 1 << $urandom_range(0, N - 1);
                    default: st = int'($urandom_range(0, (1 << N) - 1));
                endcase
            end
            fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << N) - 1)) : 0;
            cyc($urandom_range(0, 150) == 0, $urandom_range(0, 7) != 0, st, fl,
                $urandom_range(0, 30) == 0);
        end
        repeat (3) @(posedge clk);
        chk("all_checked", popped, issued);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
